// File: rtl/writeback_stage_pkg.sv
// Shared widths, opcode constants and retire-info bundle for the writeback stage.
// Optional same-cycle read forwarding is enabled by defining WB_BYPASS_EN.
package writeback_stage_pkg;

  localparam int NUM_REGS      = 16;
  localparam int NUM_VREGS     = 64;
  localparam int REG_WIDTH     = 16;
  localparam int VREG_WIDTH    = 64;
  localparam int REG_ID_WIDTH  = 4;
  localparam int VREG_ID_WIDTH = 6;
  localparam int OPCODE_WIDTH  = 8;
  localparam int CNT_WIDTH     = 16;
  localparam int CC_WIDTH      = 3;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 8'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW  = 8'h10;
  localparam logic [OPCODE_WIDTH-1:0] OP_STW  = 8'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_BR   = 8'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_JSR  = 8'h24;
  localparam logic [OPCODE_WIDTH-1:0] OP_JSRR = 8'h25;

  localparam logic [REG_ID_WIDTH-1:0] LINK_REG_IDX = 4'd15;
  localparam logic [CNT_WIDTH-1:0]    CNT_ONE      = 16'd1;

  typedef struct packed {
    logic                     valid;
    logic [REG_ID_WIDTH-1:0]  reg_idx;
    logic [VREG_ID_WIDTH-1:0] vreg_idx;
    logic                     reg_wen;
    logic                     vreg_wen;
    logic                     cc_wen;
  } wb_info_t;

  function automatic logic is_link_op(input logic [OPCODE_WIDTH-1:0] opcode);
    return (opcode == OP_JSR) || (opcode == OP_JSRR);
  endfunction

endpackage

// File: rtl/writeback_stage_wb_regfile.sv
// One-write / two-async-read register array with synchronous clear on the negedge.
// With WB_BYPASS_EN defined, reads forward the write happening in the same cycle.
module wb_regfile
  import writeback_stage_pkg::*;
#(
  parameter  int DEPTH = 16,
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wen,
  input  logic [IDX_W-1:0] widx,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0] ridx1,
  input  logic [IDX_W-1:0] ridx2,
  output logic [WIDTH-1:0] rdata1,
  output logic [WIDTH-1:0] rdata2
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata1_s;
  logic [WIDTH-1:0] rdata2_s;

  // Array update: clear wins over any write in the same cycle.
  always_ff @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wen) begin
      mem_r[widx] <= wdata;
    end
  end

  // Read ports, optionally forwarding the in-flight write.
  always_comb begin
    rdata1_s = mem_r[ridx1];
    rdata2_s = mem_r[ridx2];
`ifdef WB_BYPASS_EN
    if (wen && (widx == ridx1)) begin
      rdata1_s = wdata;
    end else begin
      rdata1_s = mem_r[ridx1];
    end
    if (wen && (widx == ridx2)) begin
      rdata2_s = wdata;
    end else begin
      rdata2_s = mem_r[ridx2];
    end
`endif
  end

  assign rdata1 = rdata1_s;
  assign rdata2 = rdata2_s;

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits the memory-stage bundle to GPRs, vector regs and CC,
// and reports retirements to decode. WB_BYPASS_EN enables same-cycle read forwarding.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_MEM_Valid,
  input  logic [OPCODE_WIDTH-1:0]  I_Opcode,
  input  logic [15:0]              I_PC,
  input  logic [31:0]              I_IR,
  input  logic [REG_WIDTH-1:0]     I_R15PC,
  input  logic [REG_ID_WIDTH-1:0]  I_DestRegIdx,
  input  logic [VREG_ID_WIDTH-1:0] I_DestVRegIdx,
  input  logic [REG_WIDTH-1:0]     I_DestValue,
  input  logic [VREG_WIDTH-1:0]    I_VecDestValue,
  input  logic [CC_WIDTH-1:0]      I_CCValue,
  input  logic                     I_RegWEn,
  input  logic                     I_VRegWEn,
  input  logic                     I_CCWEn,
  input  logic [REG_ID_WIDTH-1:0]  I_RdIdx1,
  input  logic [REG_ID_WIDTH-1:0]  I_RdIdx2,
  output logic [REG_WIDTH-1:0]     O_RdData1,
  output logic [REG_WIDTH-1:0]     O_RdData2,
  input  logic [VREG_ID_WIDTH-1:0] I_VRdIdx1,
  input  logic [VREG_ID_WIDTH-1:0] I_VRdIdx2,
  output logic [VREG_WIDTH-1:0]    O_VRdData1,
  output logic [VREG_WIDTH-1:0]    O_VRdData2,
  output logic [CC_WIDTH-1:0]      O_CC,
  output logic                     O_WB_Valid,
  output logic [REG_ID_WIDTH-1:0]  O_WB_RegIdx,
  output logic [VREG_ID_WIDTH-1:0] O_WB_VRegIdx,
  output logic                     O_WB_RegWEn,
  output logic                     O_WB_VRegWEn,
  output logic                     O_WB_CCWEn,
  output logic [CNT_WIDTH-1:0]     O_RetireCount
);

  logic                    commit_s;
  logic                    link_s;
  logic                    reg_wen_s;
  logic                    vreg_wen_s;
  logic                    cc_wen_s;
  logic [REG_ID_WIDTH-1:0] eff_idx_s;
  logic [REG_WIDTH-1:0]    eff_data_s;
  logic [CC_WIDTH-1:0]     cc_r;
  logic [CC_WIDTH-1:0]     cc_out_s;
  logic [CNT_WIDTH-1:0]    count_r;
  wb_info_t                wb_next_s;
  wb_info_t                wb_r;
  logic                    unused_trace_s;

  // PC/IR travel with the bundle for trace only.
  assign unused_trace_s = ^{I_PC, I_IR};

  assign commit_s   = I_MEM_Valid & ~I_RESET;
  assign link_s     = is_link_op(I_Opcode);
  assign reg_wen_s  = commit_s & I_RegWEn;
  assign vreg_wen_s = commit_s & I_VRegWEn;
  assign cc_wen_s   = commit_s & I_CCWEn;

  // Link ops redirect the scalar write to R15 with the return address.
  always_comb begin
    eff_idx_s  = I_DestRegIdx;
    eff_data_s = I_DestValue;
    if (link_s) begin
      eff_idx_s  = LINK_REG_IDX;
      eff_data_s = I_R15PC;
    end else begin
      eff_idx_s  = I_DestRegIdx;
      eff_data_s = I_DestValue;
    end
  end

  // Retire notification content for this cycle; all-zero when nothing commits.
  always_comb begin
    wb_next_s.valid    = commit_s;
    wb_next_s.reg_idx  = eff_idx_s;
    wb_next_s.vreg_idx = I_DestVRegIdx;
    wb_next_s.reg_wen  = reg_wen_s;
    wb_next_s.vreg_wen = vreg_wen_s;
    wb_next_s.cc_wen   = cc_wen_s;
    if (!commit_s) begin
      wb_next_s = '{valid: 1'b0, reg_idx: 4'd0, vreg_idx: 6'd0,
                    reg_wen: 1'b0, vreg_wen: 1'b0, cc_wen: 1'b0};
    end else begin
      wb_next_s.valid = 1'b1;
    end
  end

  wb_regfile #(.DEPTH(NUM_REGS), .WIDTH(REG_WIDTH)) u_gpr (
    .clk    (I_CLOCK),
    .reset  (I_RESET),
    .wen    (reg_wen_s),
    .widx   (eff_idx_s),
    .wdata  (eff_data_s),
    .ridx1  (I_RdIdx1),
    .ridx2  (I_RdIdx2),
    .rdata1 (O_RdData1),
    .rdata2 (O_RdData2)
  );

  wb_regfile #(.DEPTH(NUM_VREGS), .WIDTH(VREG_WIDTH)) u_vreg (
    .clk    (I_CLOCK),
    .reset  (I_RESET),
    .wen    (vreg_wen_s),
    .widx   (I_DestVRegIdx),
    .wdata  (I_VecDestValue),
    .ridx1  (I_VRdIdx1),
    .ridx2  (I_VRdIdx2),
    .rdata1 (O_VRdData1),
    .rdata2 (O_VRdData2)
  );

  // CC, retire counter and registered retire notification.
  always_ff @(negedge I_CLOCK) begin
    if (I_RESET) begin
      cc_r    <= 3'b000;
      count_r <= 16'd0;
      wb_r    <= '{valid: 1'b0, reg_idx: 4'd0, vreg_idx: 6'd0,
                   reg_wen: 1'b0, vreg_wen: 1'b0, cc_wen: 1'b0};
    end else begin
      if (cc_wen_s) begin
        cc_r <= I_CCValue;
      end
      if (commit_s) begin
        count_r <= count_r + CNT_ONE;
      end
      wb_r <= wb_next_s;
    end
  end

  // CC read port, optionally forwarding the same-cycle CC write.
  always_comb begin
    cc_out_s = cc_r;
`ifdef WB_BYPASS_EN
    if (cc_wen_s) begin
      cc_out_s = I_CCValue;
    end else begin
      cc_out_s = cc_r;
    end
`endif
  end

  assign O_CC          = cc_out_s;
  assign O_RetireCount = count_r;
  assign O_WB_Valid    = wb_r.valid;
  assign O_WB_RegIdx   = wb_r.reg_idx;
  assign O_WB_VRegIdx  = wb_r.vreg_idx;
  assign O_WB_RegWEn   = wb_r.reg_wen;
  assign O_WB_VRegWEn  = wb_r.vreg_wen;
  assign O_WB_CCWEn    = wb_r.cc_wen;

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: directed bundles push expected retire info,
// a posedge monitor pops and compares whenever O_WB_Valid is presented.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic        I_CLOCK = 1'b0;
  logic        I_RESET;
  logic        I_MEM_Valid;
  logic [7:0]  I_Opcode;
  logic [15:0] I_PC;
  logic [31:0] I_IR;
  logic [15:0] I_R15PC;
  logic [3:0]  I_DestRegIdx;
  logic [5:0]  I_DestVRegIdx;
  logic [15:0] I_DestValue;
  logic [63:0] I_VecDestValue;
  logic [2:0]  I_CCValue;
  logic        I_RegWEn, I_VRegWEn, I_CCWEn;
  logic [3:0]  I_RdIdx1, I_RdIdx2;
  logic [15:0] O_RdData1, O_RdData2;
  logic [5:0]  I_VRdIdx1, I_VRdIdx2;
  logic [63:0] O_VRdData1, O_VRdData2;
  logic [2:0]  O_CC;
  logic        O_WB_Valid;
  logic [3:0]  O_WB_RegIdx;
  logic [5:0]  O_WB_VRegIdx;
  logic        O_WB_RegWEn, O_WB_VRegWEn, O_WB_CCWEn;
  logic [15:0] O_RetireCount;

  int checks = 0;
  int passes = 0;
  logic [15:0] cnt_model = 16'd0;
  logic [28:0] exp_q[$];

  writeback_stage dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_MEM_Valid(I_MEM_Valid), .I_Opcode(I_Opcode),
    .I_PC(I_PC), .I_IR(I_IR), .I_R15PC(I_R15PC), .I_DestRegIdx(I_DestRegIdx),
    .I_DestVRegIdx(I_DestVRegIdx), .I_DestValue(I_DestValue), .I_VecDestValue(I_VecDestValue),
    .I_CCValue(I_CCValue), .I_RegWEn(I_RegWEn), .I_VRegWEn(I_VRegWEn), .I_CCWEn(I_CCWEn),
    .I_RdIdx1(I_RdIdx1), .I_RdIdx2(I_RdIdx2), .O_RdData1(O_RdData1), .O_RdData2(O_RdData2),
    .I_VRdIdx1(I_VRdIdx1), .I_VRdIdx2(I_VRdIdx2), .O_VRdData1(O_VRdData1), .O_VRdData2(O_VRdData2),
    .O_CC(O_CC), .O_WB_Valid(O_WB_Valid), .O_WB_RegIdx(O_WB_RegIdx), .O_WB_VRegIdx(O_WB_VRegIdx),
    .O_WB_RegWEn(O_WB_RegWEn), .O_WB_VRegWEn(O_WB_VRegWEn), .O_WB_CCWEn(O_WB_CCWEn),
    .O_RetireCount(O_RetireCount)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: sampled on posedge, midway between committing negedges.
  always @(posedge I_CLOCK) begin
    if (O_WB_Valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL wb_spurious: got valid retire idx %0d expected none", O_WB_RegIdx);
      end else begin
        logic [28:0] e;
        e = exp_q.pop_front();
        check("wb_retire",
              {35'd0, O_WB_RegIdx, O_WB_VRegIdx, O_WB_RegWEn, O_WB_VRegWEn, O_WB_CCWEn, O_RetireCount},
              {35'd0, e});
      end
    end
  end

  task automatic set_bundle(input logic [7:0] op, input logic [15:0] r15, input logic [3:0] didx,
                            input logic [5:0] dvidx, input logic [15:0] dval, input logic [63:0] vval,
                            input logic [2:0] cc, input logic rw, input logic vw, input logic cw,
                            input logic valid, input logic rst);
    logic [3:0] eidx;
    I_Opcode = op; I_R15PC = r15; I_DestRegIdx = didx; I_DestVRegIdx = dvidx;
    I_DestValue = dval; I_VecDestValue = vval; I_CCValue = cc;
    I_RegWEn = rw; I_VRegWEn = vw; I_CCWEn = cw; I_MEM_Valid = valid; I_RESET = rst;
    I_PC = 16'h0100; I_IR = 32'h0;
    if (rst) begin
      cnt_model = 16'd0;
    end else if (valid) begin
      cnt_model = cnt_model + 16'd1;
      eidx = (op == OP_JSR || op == OP_JSRR) ? 4'd15 : didx;
      exp_q.push_back({eidx, dvidx, rw, vw, cw, cnt_model});
    end
  endtask

  task automatic finish_cycle();
    @(negedge I_CLOCK);
    #1;
    I_MEM_Valid = 1'b0; I_RegWEn = 1'b0; I_VRegWEn = 1'b0; I_CCWEn = 1'b0; I_RESET = 1'b0;
  endtask

  task automatic issue(input logic [7:0] op, input logic [15:0] r15, input logic [3:0] didx,
                       input logic [5:0] dvidx, input logic [15:0] dval, input logic [63:0] vval,
                       input logic [2:0] cc, input logic rw, input logic vw, input logic cw,
                       input logic valid, input logic rst);
    set_bundle(op, r15, didx, dvidx, dval, vval, cc, rw, vw, cw, valid, rst);
    finish_cycle();
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] b);
    I_RdIdx1 = a; I_RdIdx2 = b; #1;
  endtask

  task automatic vrd(input logic [5:0] a, input logic [5:0] b);
    I_VRdIdx1 = a; I_VRdIdx2 = b; #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    I_RdIdx1 = 4'd0; I_RdIdx2 = 4'd0; I_VRdIdx1 = 6'd0; I_VRdIdx2 = 6'd0;
    set_bundle(OP_ADD, 16'd0, 4'd0, 6'd0, 16'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge I_CLOCK);
    @(negedge I_CLOCK);
    #1;
    I_RESET = 1'b0;

    // 1. reset state
    for (int i = 0; i < 16; i++) begin
      rd(4'(i), 4'(15 - i));
      check("rst_gpr1", {48'd0, O_RdData1}, 64'd0);
      check("rst_gpr2", {48'd0, O_RdData2}, 64'd0);
    end
    for (int i = 0; i < 64; i++) begin
      vrd(6'(i), 6'(63 - i));
      check("rst_vreg1", O_VRdData1, 64'd0);
      check("rst_vreg2", O_VRdData2, 64'd0);
    end
    check("rst_cc", {61'd0, O_CC}, 64'd0);
    check("rst_count", {48'd0, O_RetireCount}, 64'd0);
    check("rst_wb_valid", {63'd0, O_WB_Valid}, 64'd0);

    // 2. plain scalar write
    issue(OP_ADD, 16'd0, 4'd3, 6'd0, 16'h1234, 64'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(4'd3, 4'd3);
    check("gpr3_p1", {48'd0, O_RdData1}, 64'h1234);
    check("gpr3_p2", {48'd0, O_RdData2}, 64'h1234);
    check("wb_valid_t2", {63'd0, O_WB_Valid}, 64'd1);
    check("wb_idx_t2", {60'd0, O_WB_RegIdx}, 64'd3);

    // 3. link ops target R15 and leave the named destination alone
    issue(OP_LDW, 16'd0, 4'd2, 6'd0, 16'hAAAA, 64'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(OP_JSR, 16'h0040, 4'd2, 6'd0, 16'h5555, 64'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(4'd15, 4'd2);
    check("jsr_r15", {48'd0, O_RdData1}, 64'h0040);
    check("jsr_r2", {48'd0, O_RdData2}, 64'hAAAA);
    check("jsr_wb_idx", {60'd0, O_WB_RegIdx}, 64'd15);
    issue(OP_JSRR, 16'h0080, 4'd7, 6'd0, 16'h7777, 64'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    rd(4'd15, 4'd7);
    check("jsrr_r15", {48'd0, O_RdData1}, 64'h0080);
    check("jsrr_r7", {48'd0, O_RdData2}, 64'd0);

    // 4. vector + CC write
    issue(OP_ADD, 16'd0, 4'd0, 6'd63, 16'd0, 64'hDEAD_BEEF_0123_4567, 3'b010,
          1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    vrd(6'd63, 6'd62);
    check("vreg63", O_VRdData1, 64'hDEAD_BEEF_0123_4567);
    check("vreg62", O_VRdData2, 64'd0);
    check("cc_t4", {61'd0, O_CC}, 64'b010);

    // 5. invalid bundle with enables set changes nothing
    issue(OP_ADD, 16'd0, 4'd3, 6'd63, 16'hFFFF, 64'd0, 3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    rd(4'd3, 4'd15);
    vrd(6'd63, 6'd0);
    check("inv_gpr3", {48'd0, O_RdData1}, 64'h1234);
    check("inv_vreg63", O_VRdData1, 64'hDEAD_BEEF_0123_4567);
    check("inv_cc", {61'd0, O_CC}, 64'b010);
    check("inv_wb_valid", {63'd0, O_WB_Valid}, 64'd0);
    check("inv_count", {48'd0, O_RetireCount}, 64'd5);

    // no-enable retire (store)
    issue(OP_STW, 16'd0, 4'd1, 6'd1, 16'h1111, 64'd1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("stw_count", {48'd0, O_RetireCount}, 64'd6);
    check("stw_cc", {61'd0, O_CC}, 64'b010);

    // same-cycle read of an in-flight write
    set_bundle(OP_ADD, 16'd0, 4'd9, 6'd9, 16'hBEEF, 64'hCAFE, 3'b001, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rd(4'd9, 4'd3);
    vrd(6'd9, 6'd63);
`ifdef WB_BYPASS_EN
    check("byp_gpr9", {48'd0, O_RdData1}, 64'hBEEF);
    check("byp_vreg9", O_VRdData1, 64'hCAFE);
    check("byp_cc", {61'd0, O_CC}, 64'b001);
`else
    check("nobyp_gpr9", {48'd0, O_RdData1}, 64'd0);
    check("nobyp_vreg9", O_VRdData1, 64'd0);
    check("nobyp_cc", {61'd0, O_CC}, 64'b010);
`endif
    check("byp_other", {48'd0, O_RdData2}, 64'h1234);
    finish_cycle();
    rd(4'd9, 4'd9);
    check("post_gpr9", {48'd0, O_RdData1}, 64'hBEEF);
    check("post_cc", {61'd0, O_CC}, 64'b001);

    // 6. write concurrent with reset is dropped
    issue(OP_ADD, 16'd0, 4'd5, 6'd5, 16'h0505, 64'h5, 3'b100, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    rd(4'd5, 4'd3);
    vrd(6'd5, 6'd63);
    check("rstw_gpr5", {48'd0, O_RdData1}, 64'd0);
    check("rstw_gpr3", {48'd0, O_RdData2}, 64'd0);
    check("rstw_vreg5", O_VRdData1, 64'd0);
    check("rstw_vreg63", O_VRdData2, 64'd0);
    check("rstw_cc", {61'd0, O_CC}, 64'd0);
    check("rstw_count", {48'd0, O_RetireCount}, 64'd0);
    check("rstw_wb_valid", {63'd0, O_WB_Valid}, 64'd0);

    // counter wrap after 65536 retirements
    for (int i = 0; i < 65535; i++) begin
      issue(OP_BR, 16'd0, 4'd0, 6'd0, 16'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("count_max", {48'd0, O_RetireCount}, 64'hFFFF);
    issue(OP_BR, 16'd0, 4'd0, 6'd0, 16'd0, 64'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("count_wrap", {48'd0, O_RetireCount}, 64'd0);

    @(posedge I_CLOCK);
    #1;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
